// File: rtl/fp_pkg.sv
// fp_pkg: shared field widths, bias default, status codes and FSM states for fp_to_int
package fp_pkg;
    localparam int INT_W        = 32;
    localparam int EXP_W        = 6;
    localparam int MAN_W        = 25;
    localparam int BIAS_DEFAULT = 31;

    typedef enum logic [3:0] {
        ST_EXACT   = 4'd0,
        ST_OVF     = 4'd1,
        ST_UNF     = 4'd2,
        ST_INEXACT = 4'd3
    } status_e;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        SHIFT,
        FINISH
    } state_e;
endpackage

// File: rtl/fp_to_int.sv
// fp_to_int: multi-cycle float (s|e6|m25, hidden 1) to 32-bit two's-complement integer converter
//   reset        in   async active-low reset
//   clock_100kHz in   sole clock, rising edge
//   start        in   conversion request, sampled only in IDLE
//   fp_in        in   32-bit float operand
//   int_out      out  integer result, held until the next done
//   status_out   out  0 exact, 1 overflow, 2 underflow, 3 inexact
//   busy         out  high from DECODE through FINISH
//   done         out  one-cycle pulse with int_out/status_out valid
// Define FP2INT_ROUND_EN to round to nearest-even instead of truncating toward zero.
module fp_to_int
    import fp_pkg::*;
#(
    parameter int BIAS = BIAS_DEFAULT
) (
    input  logic        reset,
    input  logic        clock_100kHz,
    input  logic        start,
    input  logic [31:0] fp_in,
    output logic [31:0] int_out,
    output logic [3:0]  status_out,
    output logic        busy,
    output logic        done
);
    localparam int EW = EXP_W + 2;
    localparam int E_MAX_I = INT_W - 1;
    localparam logic signed [EW-1:0] E_BIAS = BIAS[EW-1:0];
    localparam logic signed [EW-1:0] E_PT   = MAN_W[EW-1:0];
    localparam logic signed [EW-1:0] E_MAX  = E_MAX_I[EW-1:0];

    state_e        state_q, state_d;
    status_e       pre_q, pre_d, st_q, st_d;
    logic [31:0]   fp_q, fp_d, work_q, work_d, int_q, int_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          left_q, left_d, guard_q, guard_d, sticky_q, sticky_d, done_q, done_d;

    logic [EXP_W-1:0]       exp_f;
    logic signed [EW-1:0]   e, sh;
    logic [32:0]            mag, limit;
    logic                   rnd;

    assign exp_f = fp_q[30:25];
    assign e     = $signed({2'b00, exp_f}) - E_BIAS;
    // distance from the binary point of the 26-bit significand
    assign sh    = e - E_PT;

    always_comb begin
`ifdef FP2INT_ROUND_EN
        rnd = guard_q & (sticky_q | work_q[0]);
`else
        rnd = 1'b0;
`endif
    end

    // largest magnitude each sign can represent: 2^31 for negatives, 2^31-1 otherwise
    assign mag   = {1'b0, work_q} + {32'd0, rnd};
    assign limit = {1'b0, fp_q[31], {31{~fp_q[31]}}};

    always_comb begin
        state_d  = state_q;
        fp_d     = fp_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        pre_d    = pre_q;
        int_d    = int_q;
        st_d     = st_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                fp_d    = start ? fp_in : fp_q;
                state_d = start ? DECODE : IDLE;
            end
            DECODE: begin
                work_d   = 32'({1'b1, fp_q[24:0]});
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                left_d   = !sh[EW-1] && sh != '0;
                cnt_d    = sh[EW-1] ? 6'(-sh) : 6'(sh);
                pre_d    = ST_EXACT;
                state_d  = FINISH;
                if (exp_f == '0) begin
                    work_d = '0;
                end else if (exp_f == '1 || e > E_MAX) begin
                    pre_d = ST_OVF;
                end else if (e[EW-1]) begin
                    pre_d  = ST_UNF;
                    work_d = '0;
                end else begin
                    state_d = (sh == '0) ? FINISH : SHIFT;
                end
            end
            SHIFT: begin
                work_d   = left_q ? work_q << 1 : work_q >> 1;
                guard_d  = left_q ? guard_q : work_q[0];
                sticky_d = left_q ? sticky_q : sticky_q | guard_q;
                cnt_d    = cnt_q - 6'd1;
                state_d  = (cnt_q == 6'd1) ? FINISH : SHIFT;
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (pre_q == ST_OVF || mag > limit) begin
                    int_d = fp_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    st_d  = ST_OVF;
                end else if (pre_q == ST_UNF) begin
                    int_d = '0;
                    st_d  = ST_UNF;
                end else begin
                    int_d = fp_q[31] ? -mag[31:0] : mag[31:0];
                    st_d  = (guard_q | sticky_q) ? ST_INEXACT : ST_EXACT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            fp_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            pre_q    <= ST_EXACT;
            int_q    <= '0;
            st_q     <= ST_EXACT;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fp_q     <= fp_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            pre_q    <= pre_d;
            int_q    <= int_d;
            st_q     <= st_d;
            done_q   <= done_d;
        end
    end

    assign int_out    = int_q;
    assign status_out = st_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: randomized and directed self-checking bench for fp_to_int against an arithmetic model
module tb_fp_to_int;
    logic        reset = 1'b0;
    logic        clock_100kHz = 1'b0;
    logic        start = 1'b0;
    logic [31:0] fp_in = '0;
    logic [31:0] int_out;
    logic [3:0]  status_out;
    logic        busy;
    logic        done;
    int vectors = 0;
    int errors = 0;

    fp_to_int dut (
        .reset(reset),
        .clock_100kHz(clock_100kHz),
        .start(start),
        .fp_in(fp_in),
        .int_out(int_out),
        .status_out(status_out),
        .busy(busy),
        .done(done)
    );

    always #5 clock_100kHz = ~clock_100kHz;

    // value = 1.m * 2^(exp-31); latency counts the start-sampling edge as clock 1
    function automatic void model(input logic [31:0] f, output logic [31:0] r, output logic [3:0] st, output int lat);
        int ex = int'(f[30:25]);
        int e = ex - 31;
        longint sig = longint'(f[24:0]) + (64'sd1 <<< 25);
        longint mag, rem, half, lim;
        logic s = f[31];
        r = '0;
        st = 4'd0;
        lat = 3;
        if (ex == 0) return;
        if (ex == 63 || e > 31) begin
            r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            st = 4'd1;
            return;
        end
        if (e < 0) begin
            st = 4'd2;
            return;
        end
        lat = 3 + ((e >= 25) ? e - 25 : 25 - e);
        if (e >= 25) begin
            mag = sig * (64'sd1 <<< (e - 25));
            rem = 0;
            half = 1;
        end else begin
            mag = sig / (64'sd1 <<< (25 - e));
            rem = sig - mag * (64'sd1 <<< (25 - e));
            half = 64'sd1 <<< (24 - e);
        end
`ifdef FP2INT_ROUND_EN
        if (rem > half || (rem == half && (mag % 2) == 1)) mag = mag + 1;
`endif
        lim = s ? 64'sh8000_0000 : 64'sh7FFF_FFFF;
        if (mag > lim) begin
            r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            st = 4'd1;
        end else begin
            r = s ? 32'(-mag) : 32'(mag);
            st = (rem != 0) ? 4'd3 : 4'd0;
        end
    endfunction

    // issues one request now (caller is away from the clock edge) and waits for done, bounded
    task automatic convert(input logic [31:0] f, output logic [31:0] r, output logic [3:0] st, output int lat);
        start = 1'b1;
        fp_in = f;
        @(posedge clock_100kHz);
        #1;
        lat = 1;
        start = 1'b0;
        fp_in = $urandom();
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clock_100kHz);
            #1;
            lat++;
        end
        r = int_out;
        st = status_out;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fp_in = 32'h3E00_0000;
        start = 1'b1;
        repeat (3) @(posedge clock_100kHz);
        #1;
        vectors++;
        if ({busy, done, int_out, status_out} !== 38'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b int=%h st=%0d, expected all zero", busy, done, int_out, status_out);
        end
        start = 1'b0;
        @(negedge clock_100kHz);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock_100kHz);
            #1;
            fp_in = $urandom();
            vectors++;
            if ({busy, done, int_out, status_out} !== 38'h0) begin
                errors++;
                $display("FAIL reset_hold: got busy=%b done=%b int=%h st=%0d, expected all zero", busy, done, int_out, status_out);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] fv[10] = '{32'h3E00_0000, 32'h4080_0000, 32'hC100_0000, 32'hFC00_0000, 32'h7E00_0000,
                                32'h3C00_0000, 32'h0000_0000, 32'hBE00_0000, 32'h7C00_0000, 32'h7000_0000};
        logic [31:0] rv[10] = '{32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFF,
                                32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0200_0000};
        logic [3:0]  sv[10] = '{4'd0, 4'd3, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd1, 4'd0};
        int          lv[10] = '{28, 27, 27, 9, 3, 3, 3, 28, 9, 3};
        logic [31:0] r;
        logic [3:0]  st;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            convert(fv[i], r, st, lat);
            vectors++;
            if (r !== rv[i] || st !== sv[i] || lat != lv[i]) begin
                errors++;
                $display("FAIL directed_%h: got int=%h st=%0d lat=%0d, expected int=%h st=%0d lat=%0d", fv[i], r, st, lat, rv[i], sv[i], lv[i]);
            end
        end
    endtask

    task automatic test_done_pulse();
        logic [31:0] r;
        logic [3:0]  st;
        int          lat;
        convert(32'hC100_0000, r, st, lat);
        @(posedge clock_100kHz);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b one cycle after done, expected 0 0", done, busy);
        end
        repeat (3) begin
            fp_in = $urandom();
            @(posedge clock_100kHz);
            #1;
            vectors++;
            if (int_out !== 32'hFFFF_FFFD || status_out !== 4'd0) begin
                errors++;
                $display("FAIL result_hold: got int=%h st=%0d, expected int=fffffffd st=0", int_out, status_out);
            end
        end
    endtask

    task automatic test_exponent_sweep();
        logic [31:0] f, r, er;
        logic [3:0]  st, est;
        int          lat, elat;
        for (int ex = 0; ex < 64; ex++) begin
            f = {1'($urandom()), 6'(ex), 25'($urandom())};
            model(f, er, est, elat);
            convert(f, r, st, lat);
            vectors++;
            if (r !== er || st !== est || lat != elat) begin
                errors++;
                $display("FAIL sweep_%h: got int=%h st=%0d lat=%0d, expected int=%h st=%0d lat=%0d", f, r, st, lat, er, est, elat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] f, r, er;
        logic [3:0]  st, est;
        int          lat, elat;
        for (int i = 0; i < 60; i++) begin
            f = $urandom();
            if (i % 2 == 0) f[30:25] = 6'($urandom_range(24, 63));
            if (i % 3 == 0) f[15:0] = '0;
            model(f, er, est, elat);
            convert(f, r, st, lat);
            vectors++;
            if (r !== er || st !== est || lat != elat) begin
                errors++;
                $display("FAIL random_%h: got int=%h st=%0d lat=%0d, expected int=%h st=%0d lat=%0d", f, r, st, lat, er, est, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] f, r, er;
        logic [3:0]  st, est;
        int          lat, elat;
        for (int i = 0; i < 8; i++) begin
            f = {1'($urandom()), 6'($urandom_range(30, 62)), 25'($urandom())};
            model(f, er, est, elat);
            convert(f, r, st, lat);
            vectors++;
            if (r !== er || st !== est || lat != elat) begin
                errors++;
                $display("FAIL back_to_back_%h: got int=%h st=%0d lat=%0d, expected int=%h st=%0d lat=%0d", f, r, st, lat, er, est, elat);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] r;
        logic [3:0]  st;
        int          lat;
        convert(32'hC100_0000, r, st, lat);
        start = 1'b1;
        fp_in = 32'h3E00_0000;
        @(posedge clock_100kHz);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock_100kHz);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_shift: got busy=%b, expected 1", busy);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({busy, done, int_out, status_out} !== 38'h0) begin
            errors++;
            $display("FAIL reset_mid_shift: got busy=%b done=%b int=%h st=%0d, expected all zero", busy, done, int_out, status_out);
        end
        @(negedge clock_100kHz);
        reset = 1'b1;
        @(negedge clock_100kHz);
        convert(32'h3E00_0000, r, st, lat);
        vectors++;
        if (r !== 32'h1 || st !== 4'd0 || lat != 28) begin
            errors++;
            $display("FAIL after_reset_conv: got int=%h st=%0d lat=%0d, expected int=00000001 st=0 lat=28", r, st, lat);
        end
    endtask

    task automatic test_start_while_busy();
        int          ndone = 0;
        logic [31:0] r = '0;
        logic [3:0]  st = '1;
        @(negedge clock_100kHz);
        start = 1'b1;
        fp_in = 32'h3E00_0000;
        @(posedge clock_100kHz);
        #1;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5 || c == 26) begin
                start = 1'b1;
                fp_in = 32'hC100_0000;
            end else begin
                start = 1'b0;
            end
            @(posedge clock_100kHz);
            #1;
            if (done === 1'b1) begin
                ndone++;
                r = int_out;
                st = status_out;
            end
            if (ndone == 1 && c > 30) start = 1'b0;
        end
        start = 1'b0;
        vectors++;
        if (ndone != 1 || r !== 32'h1 || st !== 4'd0) begin
            errors++;
            $display("FAIL start_while_busy: got %0d done pulses int=%h st=%0d, expected 1 pulse int=00000001 st=0", ndone, r, st);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clock_100kHz);
        test_directed();
        test_done_pulse();
        test_exponent_sweep();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
